// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/allow inter-stage register with optional skid entry and NOP fill.
// Optional perf counters (stall/bubble) are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic              in_done_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_allow_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_allow_i,
  output logic [1:0]        occ_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKIDDED = 2'd2} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              allow_q, allow_d, acc, pop;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o  = out_valid_o ? main_q : NOP_VAL;
  assign occ_o       = state_q == SKIDDED ? 2'd2 : {1'b0, out_valid_o};
  // with a skid entry allow-in comes straight from a flop, cutting the ready chain
  assign in_allow_o  = SKID ? allow_q : (~out_valid_o | out_allow_i);
  assign acc         = in_valid_i & in_done_i & in_allow_o & ~flush_i;
  assign pop         = out_valid_o & out_allow_i;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          state_d = acc ? FULL : EMPTY;
          main_d  = acc ? in_data_i : main_q;
        end
        FULL: begin
          if (acc && (pop || !SKID)) begin
            main_d = in_data_i;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
          end else if (acc) begin
            state_d = SKIDDED;
            skid_d  = in_data_i;
          end
        end
        SKIDDED: begin
          state_d = pop ? FULL : SKIDDED;
          main_d  = pop ? skid_q : main_q;
          skid_d  = pop ? NOP_VAL : skid_q;
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
    allow_d = state_d != SKIDDED;
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      allow_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      allow_q <= allow_d;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, stall_d, bubble_q, bubble_d;
  // the reduction-AND term freezes each counter at all-ones
  assign stall_d      = stall_q + 32'(out_valid_o & ~out_allow_i & ~&stall_q);
  assign bubble_d     = bubble_q + 32'(~out_valid_o & out_allow_i & ~&bubble_q);
  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of the skid (a_*) and single-entry (b_*) builds.
module tb_pipe_stage_buf;
  localparam logic [63:0] NOP_A = 64'hDEAD_BEEF;
  localparam logic [15:0] NOP_B = 16'h005A;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_flush, a_in_valid, a_in_done, a_in_allow, a_out_valid, a_out_allow;
  logic [63:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic [31:0] a_stall, a_bubble;
  logic b_flush, b_in_valid, b_in_done, b_in_allow, b_out_valid, b_out_allow;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic [31:0] b_stall, b_bubble;
  logic [31:0] base;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pipe_stage_buf #(.DATA_W(64), .NOP_VAL(NOP_A), .SKID(1'b1)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .flush_i(a_flush), .in_valid_i(a_in_valid),
    .in_done_i(a_in_done), .in_data_i(a_in_data), .in_allow_o(a_in_allow),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_allow_i(a_out_allow),
    .occ_o(a_occ), .stall_cnt_o(a_stall), .bubble_cnt_o(a_bubble));
  pipe_stage_buf #(.DATA_W(16), .NOP_VAL(NOP_B), .SKID(1'b0)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .flush_i(b_flush), .in_valid_i(b_in_valid),
    .in_done_i(b_in_done), .in_data_i(b_in_data), .in_allow_o(b_in_allow),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_allow_i(b_out_allow),
    .occ_o(b_occ), .stall_cnt_o(b_stall), .bubble_cnt_o(b_bubble));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_state(input string tag, input logic v, input logic [63:0] d, input logic [1:0] o, input logic al);
    chk({tag, "_valid"}, 64'(a_out_valid), 64'(v));
    chk({tag, "_data"}, a_out_data, d);
    chk({tag, "_occ"}, 64'(a_occ), 64'(o));
    chk({tag, "_allow"}, 64'(a_in_allow), 64'(al));
  endtask
  initial begin
    a_flush = 0; a_in_valid = 1; a_in_done = 1; a_in_data = 64'h55; a_out_allow = 1;
    b_flush = 0; b_in_valid = 1; b_in_done = 1; b_in_data = 16'h55; b_out_allow = 1;
    tick(); tick();
    a_state("rst", 0, NOP_A, 0, 1);
    chk("rst_b_valid", 64'(b_out_valid), 0);
    chk("rst_b_data", 64'(b_out_data), 64'(NOP_B));
    chk("rst_b_allow", 64'(b_in_allow), 1);
    chk("rst_stall", 64'(a_stall), 0);
    chk("rst_bubble", 64'(a_bubble), 0);
    b_in_valid = 0;
    rst_n = 1;
    a_in_data = 64'h1;
    tick();
    a_state("first", 1, 64'h1, 1, 1);
    for (int i = 2; i <= 8; i++) begin
      a_in_data = 64'(i);
      tick();
      a_state($sformatf("stream%0d", i), 1, 64'(i), 1, 1);
    end
    a_in_valid = 0;
    tick();
    a_state("drain", 0, NOP_A, 0, 1);
    a_out_allow = 0; a_in_valid = 1; a_in_data = 64'hA;
    tick();
    a_state("bp_a", 1, 64'hA, 1, 1);
    a_in_data = 64'hB;
    tick();
    a_state("bp_b", 1, 64'hA, 2, 0);
    a_in_data = 64'hC;
    tick();
    a_state("bp_c_held", 1, 64'hA, 2, 0);
    a_out_allow = 1;
    tick();
    a_state("bp_out_b", 1, 64'hB, 1, 1);
    tick();
    a_state("bp_out_c", 1, 64'hC, 1, 1);
    a_in_valid = 0;
    tick();
    a_state("bp_empty", 0, NOP_A, 0, 1);
    a_out_allow = 0; a_in_valid = 1; a_in_data = 64'hA;
    tick();
    a_in_data = 64'hB;
    tick();
    a_state("fl_pre", 1, 64'hA, 2, 0);
    a_flush = 1; a_in_data = 64'hD;
    tick();
    a_state("fl", 0, NOP_A, 0, 1);
    a_flush = 0; a_in_valid = 0;
    tick();
    a_state("fl_after", 0, NOP_A, 0, 1);
    a_out_allow = 1; a_in_valid = 1; a_in_done = 0; a_in_data = 64'h77;
    base = a_bubble;
    tick(); tick(); tick();
    a_state("mc_wait", 0, NOP_A, 0, 1);
    a_in_done = 1;
    tick();
    a_in_valid = 0;
    a_state("mc_cap", 1, 64'h77, 1, 1);
    chk("mc_bubble", 64'(a_bubble), PERF ? 64'(base + 32'd4) : 64'd0);
    a_out_allow = 0;
    base = a_stall;
    tick(); tick();
    a_state("stall_hold", 1, 64'h77, 1, 1);
    chk("stall_cnt", 64'(a_stall), PERF ? 64'(base + 32'd2) : 64'd0);
    a_out_allow = 1;
    tick();
    a_state("stall_rel", 0, NOP_A, 0, 1);
    b_out_allow = 0; b_in_valid = 1; b_in_data = 16'h11;
    tick();
    chk("b_cap_valid", 64'(b_out_valid), 1);
    chk("b_cap_data", 64'(b_out_data), 64'h11);
    chk("b_cap_occ", 64'(b_occ), 1);
    b_in_data = 16'h22;
    #1;
    chk("b_allow_blocked", 64'(b_in_allow), 0);
    tick();
    chk("b_hold_data", 64'(b_out_data), 64'h11);
    b_out_allow = 1;
    #1;
    chk("b_allow_comb", 64'(b_in_allow), 1);
    tick();
    chk("b_repl_data", 64'(b_out_data), 64'h22);
    chk("b_repl_occ", 64'(b_occ), 1);
    b_in_valid = 0;
    tick();
    chk("b_empty_occ", 64'(b_occ), 0);
    chk("b_empty_data", 64'(b_out_data), 64'(NOP_B));
    b_flush = 1; b_in_valid = 1; b_in_data = 16'h33;
    tick();
    chk("b_flush_valid", 64'(b_out_valid), 0);
    b_flush = 0; b_in_valid = 0;
    a_in_valid = 1; a_in_data = 64'hE; a_out_allow = 0;
    tick();
    a_state("ar_pre", 1, 64'hE, 1, 1);
    #2 rst_n = 0;
    #1;
    a_state("ar", 0, NOP_A, 0, 1);
    chk("ar_bubble", 64'(a_bubble), 0);
    a_in_valid = 0;
    tick();
    rst_n = 1;
    tick();
    a_state("ar_post", 0, NOP_A, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline register, the successor to the fixed per-stage latches (decode→execute, execute→memory, …).
- Carries one flattened payload bus with a valid/allow-in handshake, a "stage done" qualifier and synchronous flush.
- Optional second (skid) entry so allow-in is a registered signal, breaking the combinational ready chain.
- Empty slots present a programmable NOP payload downstream.

Parameters:
- DATA_W, 64, payload width in bits (all stage fields concatenated by the instantiating stage).
- NOP_VAL, {DATA_W{1'b0}}, payload driven on out_data_o whenever out_valid_o=0.
- SKID, 1, 1 = two-entry skid buffer with registered in_allow_o; 0 = single entry with combinational allow-in.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous kill of all held entries (branch mispredict / redirect).
- in_valid_i  input  1  upstream holds a valid instruction.
- in_done_i  input  1  upstream stage finished its (possibly multicycle) work this cycle.
- in_data_i  input  DATA_W  upstream payload.
- in_allow_o  output  1  this buffer can accept this cycle.
- out_valid_o  output  1  head entry valid.
- out_data_o  output  DATA_W  head payload, NOP_VAL when not valid.
- out_allow_i  input  1  downstream accepts the head this cycle.
- occ_o  output  2  number of held entries (0..2; max 1 when SKID=0).
- stall_cnt_o  output  32  perf counter (see Optional Feature).
- bubble_cnt_o  output  32  perf counter (see Optional Feature).

Behaviour:
Events and reset:
- acc = in_valid_i & in_done_i & in_allow_o & ~flush_i.
- pop = out_valid_o & out_allow_i.
- Reset (async assert, sync release) clears all outputs and counters: entries empty, out_valid_o=0, out_data_o=NOP_VAL, occ_o=0.
- SKID=1: in_allow_o resets to 1. SKID=0: in_allow_o = 1 whenever empty.
- Reset asserted mid-transfer drops the in-flight entry; no partial state survives.

Flush:
- flush_i has priority over acc and pop. Next edge: all entries invalid, payload registers loaded with NOP_VAL, occ_o=0.
- No acceptance in the flush cycle. pop may still be seen downstream that cycle; the downstream stage must honour the flush itself.

SKID=0 (states EMPTY, FULL):
- in_allow_o = ~out_valid_o | out_allow_i (combinational).
- EMPTY→FULL on acc. FULL→EMPTY on pop & ~acc. FULL stays FULL on pop & acc, with new payload loaded. No change otherwise.

SKID=1 (states EMPTY, FULL, SKIDDED; main + skid registers):
- in_allow_o = ~skid_valid, registered (state ≠ SKIDDED).
- EMPTY: acc → main←in, FULL.
- FULL, pop & acc: main←in, stay FULL.
- FULL, pop & ~acc: EMPTY.
- FULL, ~pop & acc: skid←in, SKIDDED.
- SKIDDED: acc impossible. On pop, main←skid, skid←NOP_VAL, FULL.
- Ordering strictly FIFO; head is always main.

General:
- Latency: accepted payload appears on out_data_o one cycle after acc when buffer empty.
- Throughput: 1/cycle with out_allow_i held high.
- out_data_o is NOP_VAL whenever out_valid_o=0. Payload registers are rewritten to NOP_VAL on pop-to-empty so the head never shows stale data.
- in_done_i=0 with in_valid_i=1 inserts a bubble; nothing captured.
- in_data_i is ignored unless acc.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle out_valid_o & ~out_allow_i.
  - bubble_cnt_o increments each cycle ~out_valid_o & out_allow_i.
  - Both saturate at 32'hFFFF_FFFF, clear on reset, are unaffected by flush_i, and are registered (value reflects cycles up to the previous edge).
- Undefined: both outputs tied to 0; no counter flops synthesised.

Test Plan:
1. Reset: hold rst_n=0, drive in_valid_i=1 in_done_i=1 → out_valid_o=0, out_data_o=NOP_VAL, occ_o=0, in_allow_o=1 (SKID=1). Release rst_n → first acc appears next cycle.
2. Streaming (SKID=1, DATA_W=64): out_allow_i=1, push 0x1..0x8 back-to-back → out_data_o shows 0x1..0x8 on consecutive cycles, 1-cycle latency, occ_o never exceeds 1.
3. Backpressure: push 0xA, 0xB while out_allow_i=0 → occ_o=2, in_allow_o=0 next cycle, 0xC held off. Raise out_allow_i → outputs 0xA, 0xB, 0xC in order, nothing lost or duplicated.
4. Flush: with 0xA,0xB held, assert flush_i together with in_valid_i=1 (0xD) → next cycle occ_o=0, out_valid_o=0, out_data_o=NOP_VAL, 0xD not captured.
5. Multicycle upstream: in_valid_i=1, in_done_i=0 for 3 cycles, then 1 → single capture. With PIPE_STAGE_PERF_EN and out_allow_i=1 throughout, bubble_cnt_o increases by 4 (3 not-done cycles + 1 capture cycle before the entry appears).
6. SKID=0: out_valid_o=1, out_allow_i=1, new acc in the same cycle → in_allow_o=1 combinationally, payload replaced next cycle, occ_o stays 1.
